// File: rtl/ysyx_23060240_csr_writer.sv
// ysyx_23060240_csr_writer
//   Write side of the machine-mode CSR file (mstatus/mtvec/mepc/mcause).
//   It runs CSRRW/CSRRS/CSRRC read-modify-writes, ECALL trap entry and MRET
//   return, one request at a time, through IDLE -> EXEC -> RESP.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               request handshake and payload from EXU (captured in IDLE)
//   rsp_*               response to WBU: old CSR value, redirect, illegal flag
//   csr_*               current architectural CSR state for the read port
module ysyx_23060240_csr_writer #(
  parameter logic [31:0] MSTATUS_RST  = 32'h0000_1800,
  parameter logic [31:0] MCAUSE_ECALL = 32'h0000_000b
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_zero,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_redirect,
  output logic [31:0] rsp_target,
  output logic        rsp_illegal,
  output logic [31:0] csr_mstatus,
  output logic [31:0] csr_mtvec,
  output logic [31:0] csr_mepc,
  output logic [31:0] csr_mcause
);

  localparam logic [2:0] OP_CSRRW = 3'b001;
  localparam logic [2:0] OP_CSRRS = 3'b010;
  localparam logic [2:0] OP_CSRRC = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  localparam logic [31:0] MPP_MASK = 32'h0000_1800;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [11:0] addr_q;
  logic [31:0] src_q, pc_q;
  logic        zero_q;

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic [31:0] rdata_q, rdata_d;
  logic        redirect_q, redirect_d;
  logic [31:0] target_q, target_d;
  logic        illegal_q, illegal_d;

  logic [31:0] old_val, wr_val;
  logic        addr_ok;

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Selected CSR and the read-modify-write value
  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    unique case (addr_q)
      12'h300: old_val = mstatus_q;
      12'h305: old_val = mtvec_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      default: addr_ok = 1'b0;
    endcase
    unique case (op_q)
      OP_CSRRS: wr_val = old_val | src_q;
      OP_CSRRC: wr_val = old_val & ~src_q;
      default:  wr_val = src_q;
    endcase
  end

  // CSR updates and response registers; only EXEC changes anything
  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    rdata_d    = rdata_q;
    redirect_d = redirect_q;
    target_d   = target_q;
    illegal_d  = illegal_q;
    if (state_q == EXEC) begin
      rdata_d    = '0;
      redirect_d = 1'b0;
      target_d   = '0;
      illegal_d  = 1'b0;
      unique case (op_q)
        OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
          if (!addr_ok) begin
            illegal_d = 1'b1;
          end else begin
            rdata_d = old_val;
            // Set/clear with a zero source is a pure read
            if (op_q == OP_CSRRW || !zero_q) begin
              unique case (addr_q)
                12'h300: mstatus_d = wr_val | MPP_MASK;
                12'h305: mtvec_d   = wr_val;
                12'h341: mepc_d    = wr_val & ~32'h3;
                default: mcause_d  = wr_val;
              endcase
            end
          end
        end
        OP_ECALL: begin
          mepc_d       = pc_q & ~32'h3;
          mcause_d     = MCAUSE_ECALL;
          mstatus_d[7] = mstatus_q[3];
          mstatus_d[3] = 1'b0;
          redirect_d   = 1'b1;
          target_d     = mtvec_q;
        end
        OP_MRET: begin
          mstatus_d[3] = mstatus_q[7];
          mstatus_d[7] = 1'b1;
          redirect_d   = 1'b1;
          target_d     = mepc_q;
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mstatus_q  <= MSTATUS_RST;
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= MCAUSE_ECALL;
      rdata_q    <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      illegal_q  <= 1'b0;
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      pc_q       <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      rdata_q    <= rdata_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      illegal_q  <= illegal_d;
      if (state_q == IDLE && req_valid) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        src_q  <= req_src;
        pc_q   <= req_pc;
        zero_q <= req_src_zero;
      end
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_redirect = redirect_q;
  assign rsp_target   = target_q;
  assign rsp_illegal  = illegal_q;
  assign csr_mstatus  = mstatus_q;
  assign csr_mtvec    = mtvec_q;
  assign csr_mepc     = mepc_q;
  assign csr_mcause   = mcause_q;

endmodule

// File: tb/tb_ysyx_23060240_csr_writer.sv
module tb_ysyx_23060240_csr_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src, req_pc;
  logic        req_src_zero;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata, rsp_target;
  logic        rsp_redirect, rsp_illegal;
  logic [31:0] csr_mstatus, csr_mtvec, csr_mepc, csr_mcause;

  ysyx_23060240_csr_writer #(
    .MSTATUS_RST (32'h0000_1800),
    .MCAUSE_ECALL(32'h0000_000b)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
    .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_redirect(rsp_redirect), .rsp_target(rsp_target),
    .rsp_illegal(rsp_illegal),
    .csr_mstatus(csr_mstatus), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .csr_mcause(csr_mcause)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: CSRs indexed 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  logic [31:0] m_csr [4];
  logic        m_idle, m_pend, chk_en;
  logic [31:0] m_rd, m_tg;
  logic        m_rdr, m_il;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int csr_idx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_csr[0] = 32'h1800; m_csr[1] = 0; m_csr[2] = 0; m_csr[3] = 32'hb;
    m_rd = 0; m_tg = 0; m_rdr = 0; m_il = 0;
  endtask

  task automatic store(input int i, input logic [31:0] v);
    if (i == 0)      m_csr[0] = v | 32'h1800;
    else if (i == 2) m_csr[2] = {v[31:2], 2'b00};
    else             m_csr[i] = v;
  endtask

  task automatic model_exec(input logic [2:0] op, input logic [11:0] addr,
                            input logic [31:0] src, input logic zero, input logic [31:0] pc);
    int i;
    logic [31:0] old, ms;
    m_rd = 0; m_tg = 0; m_rdr = 0; m_il = 0;
    i = csr_idx(addr);
    if (op >= 3'd1 && op <= 3'd3) begin
      if (i < 0) m_il = 1;
      else begin
        old = m_csr[i];
        m_rd = old;
        if (op == 3'd1)      store(i, src);
        else if (!zero)      store(i, (op == 3'd2) ? (old | src) : (old & ~src));
      end
    end else if (op == 3'd4) begin
      ms = m_csr[0];
      ms[7] = m_csr[0][3];
      ms[3] = 1'b0;
      m_tg = m_csr[1]; m_rdr = 1;
      m_csr[0] = ms; store(2, pc); m_csr[3] = 32'hb;
    end else if (op == 3'd5) begin
      ms = m_csr[0];
      ms[3] = m_csr[0][7];
      ms[7] = 1'b1;
      m_tg = m_csr[2]; m_rdr = 1;
      m_csr[0] = ms;
    end else m_il = 1;
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_idle});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_pend});
      chk("mstatus", csr_mstatus, m_csr[0]);
      chk("mtvec",   csr_mtvec,   m_csr[1]);
      chk("mepc",    csr_mepc,    m_csr[2]);
      chk("mcause",  csr_mcause,  m_csr[3]);
      if (m_pend) begin
        chk("rsp_rdata",    rsp_rdata, m_rd);
        chk("rsp_target",   rsp_target, m_tg);
        chk("rsp_redirect", {31'd0, rsp_redirect}, {31'd0, m_rdr});
        chk("rsp_illegal",  {31'd0, rsp_illegal},  {31'd0, m_il});
      end
    end
  end

  // One full transaction; optionally holds rsp_ready low for 'hold' cycles
  // while presenting a second request (bp) that must not be taken yet.
  task automatic do_req(input logic [2:0] op, input logic [11:0] addr,
                        input logic [31:0] src, input logic zero, input logic [31:0] pc,
                        input int hold, input logic bp, input logic [11:0] baddr,
                        input logic [31:0] bsrc);
    int w;
    @(negedge clk);
    req_valid = 1; req_op = op; req_addr = addr; req_src = src;
    req_src_zero = zero; req_pc = pc;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin
      $display("FAIL accept_timeout: got req_ready 0 expected 1");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1);
    end
    @(posedge clk); #1;
    m_idle = 0;
    req_valid = 0; req_op = 3'($urandom); req_addr = 12'($urandom);
    req_src = $urandom; req_pc = $urandom; req_src_zero = 1'($urandom);
    @(posedge clk); #1;
    model_exec(op, addr, src, zero, pc);
    m_pend = 1;
    rsp_ready = (hold == 0);
    if (bp) begin
      req_valid = 1; req_op = 3'b001; req_addr = baddr; req_src = bsrc;
      req_src_zero = 0;
    end
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1;
    end
    @(posedge clk); #1;
    m_pend = 0; m_idle = 1; rsp_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_src = 0;
    req_src_zero = 0; req_pc = 0; rsp_ready = 0;
    chk_en = 0; m_idle = 1; m_pend = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mstatus", csr_mstatus, 32'h1800);
    chk("rst_mcause", csr_mcause, 32'hb);
    @(negedge clk) rst = 0;

    // CSRRW mtvec
    do_req(3'b001, 12'h305, 32'h8000_0100, 0, 0, 0, 0, 0, 0);
    chk("lit_mtvec_rd", m_rd, 32'h0);
    chk("lit_mtvec", csr_mtvec, 32'h8000_0100);
    chk("lit_mstatus0", csr_mstatus, 32'h1800);
    // set / clear / zero-source read
    do_req(3'b010, 12'h300, 32'h8, 0, 0, 0, 0, 0, 0);
    chk("lit_rs_rd", m_rd, 32'h1800);
    chk("lit_rs", csr_mstatus, 32'h1808);
    do_req(3'b011, 12'h300, 32'h1808, 0, 0, 0, 0, 0, 0);
    chk("lit_rc_rd", m_rd, 32'h1808);
    chk("lit_rc", csr_mstatus, 32'h1800);
    do_req(3'b010, 12'h300, 32'hff, 1, 0, 0, 0, 0, 0);
    chk("lit_rs0", csr_mstatus, 32'h1800);
    do_req(3'b011, 12'h305, 32'hffff_ffff, 1, 0, 0, 0, 0, 0);
    chk("lit_rc0_rd", m_rd, 32'h8000_0100);
    // ECALL / MRET round trip with MIE=1
    do_req(3'b010, 12'h300, 32'h8, 0, 0, 0, 0, 0, 0);
    do_req(3'b100, 12'h000, 32'h0, 0, 32'h8000_0040, 0, 0, 0, 0);
    chk("lit_ecall_tg", m_tg, 32'h8000_0100);
    chk("lit_ecall_mepc", csr_mepc, 32'h8000_0040);
    chk("lit_ecall_mst", csr_mstatus, 32'h1880);
    chk("lit_ecall_cause", csr_mcause, 32'hb);
    do_req(3'b101, 12'h000, 32'h0, 0, 32'h1, 0, 0, 0, 0);
    chk("lit_mret_tg", m_tg, 32'h8000_0040);
    chk("lit_mret_mst", csr_mstatus, 32'h1888);
    // illegal forms
    do_req(3'b001, 12'h7c0, 32'hffff_ffff, 0, 0, 0, 0, 0, 0);
    chk("lit_ill_flag", {31'd0, m_il}, 32'd1);
    do_req(3'b111, 12'h300, 32'hffff_ffff, 0, 0, 0, 0, 0, 0);
    do_req(3'b000, 12'h305, 32'h0, 0, 0, 0, 0, 0, 0);
    do_req(3'b110, 12'h341, 32'h0, 0, 0, 0, 0, 0, 0);
    chk("lit_ill_mtvec", csr_mtvec, 32'h8000_0100);
    // masks
    do_req(3'b001, 12'h341, 32'h1237, 0, 0, 0, 0, 0, 0);
    chk("lit_mepc_mask", csr_mepc, 32'h1234);
    do_req(3'b001, 12'h342, 32'hdead_beef, 0, 0, 0, 0, 0, 0);
    chk("lit_mcause_rd", m_rd, 32'hb);
    do_req(3'b001, 12'h300, 32'h0, 0, 0, 0, 0, 0, 0);
    chk("lit_mst_mpp", csr_mstatus, 32'h1800);
    // backpressure with a second request held during RESP
    do_req(3'b001, 12'h305, 32'h1111_2220, 0, 0, 5, 1, 12'h305, 32'h3333_4440);
    chk("lit_bp_mtvec", csr_mtvec, 32'h1111_2220);
    do_req(3'b001, 12'h305, 32'h3333_4440, 0, 0, 0, 0, 0, 0);
    chk("lit_bp2_rd", m_rd, 32'h1111_2220);
    chk("lit_bp2_mtvec", csr_mtvec, 32'h3333_4440);

    // reset during EXEC drops the request
    @(negedge clk);
    req_valid = 1; req_op = 3'b001; req_addr = 12'h341; req_src = 32'h5678;
    req_src_zero = 0;
    @(posedge clk); #1 m_idle = 0; req_valid = 0;
    @(negedge clk) rst = 1;
    @(posedge clk); #1 model_reset(); m_idle = 1; m_pend = 0;
    chk("midrst_mepc", csr_mepc, 32'h0);
    chk("midrst_rdata", rsp_rdata, 32'h0);
    chk("midrst_redirect", {31'd0, rsp_redirect}, 32'd0);
    chk("midrst_target", rsp_target, 32'h0);
    @(negedge clk) rst = 0;
    repeat (4) @(posedge clk);
    #1 chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    do_req(3'b001, 12'h341, 32'h1234, 0, 0, 0, 0, 0, 0);
    chk("lit_after_rst_rd", m_rd, 32'h0);
    chk("lit_after_rst_mepc", csr_mepc, 32'h1234);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060240_csr_writer.md
# ysyx_23060240_csr_writer

Sequential CSR update unit for the single-issue core. It is the write side of the machine-mode CSR file: it owns the mstatus/mtvec/mepc/mcause state. It executes CSRRW/CSRRS/CSRRC read-modify-writes, ECALL trap entry and MRET return, and hands the old CSR value plus any PC redirect back to write-back over a valid/ready handshake. The combinational CSR read port consumes its `csr_*` state outputs.

## Interface
- `MSTATUS_RST`, 32'h0000_1800, mstatus reset value; MPP field [12:11] is hardwired 2'b11.
- `MCAUSE_ECALL`, 32'h0000_000b, cause code written on ECALL; also the mcause reset value.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  EXU presents a CSR/trap request.
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  3  3'b001 CSRRW, 3'b010 CSRRS, 3'b011 CSRRC, 3'b100 ECALL, 3'b101 MRET; all other codes are illegal.
- `req_addr`  in  12  CSR address: 12'h300 mstatus, 12'h305 mtvec, 12'h341 mepc, 12'h342 mcause.
- `req_src`  in  32  rs1 value, or the zero-extended uimm for immediate forms.
- `req_src_zero`  in  1  rs1 index/uimm is zero; suppresses the write for CSRRS/CSRRC.
- `req_pc`  in  32  PC of the requesting instruction.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  WBU accepts the response.
- `rsp_rdata`  out  32  CSR value before the update (rd data); 0 for ECALL/MRET/illegal.
- `rsp_redirect`  out  1  next PC must be `rsp_target`.
- `rsp_target`  out  32  redirect target.
- `rsp_illegal`  out  1  unknown CSR address or illegal op.
- `csr_mstatus`, `csr_mtvec`, `csr_mepc`, `csr_mcause`  out  32 each  current architectural CSR state.

## Operation
- FSM states: IDLE, EXEC, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, capture op/addr/src/src_zero/pc and go to EXEC.
  - EXEC: compute the result, update CSRs at the end of the cycle, load the response registers, go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- `req_ready`=1 only in IDLE. Request inputs may change after acceptance; only the captured copies are used.
- Let old = the selected CSR value in EXEC. Write value:
  - CSRRW: src.
  - CSRRS: old | src.
  - CSRRC: old & ~src.
  - CSRRS/CSRRC with `src_zero`=1: no write, rdata = old.
- Write masks:
  - mstatus[12:11] always stays 2'b11.
  - mepc[1:0] always stored as 0.
  - mtvec and mcause are stored unmasked.
- ECALL:
  - mepc ← pc; mcause ← `MCAUSE_ECALL`.
  - mstatus.MPIE[7] ← MIE[3]; MIE ← 0.
  - redirect=1, target = mtvec.
- MRET:
  - mstatus.MIE ← MPIE; MPIE ← 1.
  - redirect=1, target = mepc, read in EXEC before any update.
- Illegal (unknown address with op 001–011, or op not in 001–101): no CSR change; illegal=1, rdata=0, redirect=0.

## Timing
- Reset, regardless of state:
  - FSM → IDLE.
  - mstatus=32'h1800, mtvec=0, mepc=0, mcause=32'hb.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_redirect`=0, `rsp_target`=0, `rsp_illegal`=0.
  - `req_ready` is 1 in the first cycle after reset is released.
- Latency: request accepted at edge N → CSRs updated at edge N+1 → `rsp_valid` high from edge N+1 to the accepting edge.
- Minimum spacing is 3 cycles per request when `rsp_ready` is held at 1. There is no overlap: a new request is accepted only in IDLE.
- Backpressure: in RESP with `rsp_ready`=0, all `rsp_*` outputs and all CSRs hold stable for any number of cycles.
- `csr_*` outputs reflect the new values from edge N+1, before the response is consumed.
- Reset asserted in EXEC or RESP: the in-flight request is dropped, no response is delivered, and reset values win over the pending write.
- `req_valid` held high across RESP is not accepted until the cycle after the FSM returns to IDLE.

## Test plan
- Reset, then write mtvec: release `rst`; CSRRW addr 305, src 0x8000_0100 → rdata 0, `csr_mtvec`=0x8000_0100, response 2 cycles after accept, `csr_mstatus`=0x1800.
- Set/clear with mask: CSRRS 300 src 0x8 → rdata 0x1800, mstatus 0x1808. Then CSRRC 300 src 0x1808 → rdata 0x1808, mstatus 0x1800 (MPP kept). CSRRS with `src_zero`=1 → no change.
- ECALL/MRET round trip:
  - mtvec=0x8000_0100, MIE=1. ECALL pc 0x8000_0040 → redirect, target 0x8000_0100, mepc 0x8000_0040, mcause 0xb, mstatus 0x1880.
  - MRET → target 0x8000_0040, mstatus 0x1888.
- Illegal cases: CSRRW addr 0x7C0 src 0xFFFF_FFFF → illegal=1, rdata 0, all CSRs unchanged. Op 3'b111 → illegal=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → outputs stable, `req_ready`=0, a second `req_valid` is ignored until IDLE.
- Mid-op reset: assert `rst` in EXEC of CSRRW mepc 0x1234 → mepc=0, `rsp_valid` never rises, `req_ready`=1 after release.
